demux_sched: RTL and testbench
==============================

# demux_sched

Scheduler for a 1:N data demux: accepts one valid/ready input stream and steers each item to exactly one of `N_OUT` consumer ports over a shared data bus with a one-hot valid. Targets are chosen round-robin over an enable mask, or from an explicit destination field when built with `DEMUX_SCHED_DEST_EN`. It sits between a producer and a bank of consumers wherever the 1:2 demux datapath is widened and needs sequencing.

## Interface
- `N_OUT`, 4, number of output ports (2..16)
- `DW`, 8, data width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cfg_mask`  in  N_OUT  per-output enable; bit k=0 excludes port k from scheduling
- `in_valid`  in  1  input item present
- `in_ready`  out  1  input accepted when `in_valid && in_ready`
- `in_data`  in  DW  input payload
- `in_dest`  in  $clog2(N_OUT)  destination index (present only with `DEMUX_SCHED_DEST_EN`)
- `out_valid`  out  N_OUT  one-hot; bit k = item offered to port k
- `out_ready`  in  N_OUT  per-port consumer ready
- `out_data`  out  DW  shared payload bus, valid for whichever bit of `out_valid` is set
- `dispatch_cnt`  out  16  count of completed output handshakes, wraps at 2^16
- `err_drop`  out  1  one-cycle pulse when an item is accepted and discarded

## Operation
- Single holding register plus FSM: `IDLE` (empty), `HOLD` (item offered on one port).
- `in_ready = (state==IDLE || out_fire) && |cfg_mask`; `out_fire = |(out_valid & out_ready)`.
- On accept: latch `in_data` to `out_data`, compute target, set `out_valid` one-hot on it, go/stay `HOLD`.
- On `out_fire` with no accept in the same cycle: clear `out_valid`, go `IDLE`.
- Round-robin: target = first set bit of `cfg_mask` strictly after last target, wrapping modulo `N_OUT`. Last-target pointer updates on accept only.
- `out_valid` bit, once set, is never withdrawn or moved until its `out_ready`; `out_data` stable meanwhile.
- `cfg_mask` changes affect only later selections; a held item stays on its port even if that port is masked off.
- `cfg_mask == 0`: `in_ready` low, no accepts; any held item still completes.
- `dispatch_cnt` increments by 1 on each `out_fire`.

## Timing
- Reset values: state `IDLE`, `out_valid` 0, `out_data` 0, `dispatch_cnt` 0, `err_drop` 0, last-target pointer `N_OUT-1` (first round-robin target is lowest enabled port ≥ 0).
- Latency: accept at edge t → `out_valid` visible after edge t; one cycle.
- Throughput: one item per cycle when consumers keep ready high (accept and fire in same cycle).
- `in_ready` is combinational from state, `out_valid`, `out_ready`, `cfg_mask`; all other outputs registered.
- Reset asserted mid-operation: held item discarded, all outputs to reset values immediately.

## Configuration
- `DEMUX_SCHED_DEST_EN` defined: `in_dest` port exists; target = `in_dest`, round-robin pointer unused. If `in_dest >= N_OUT` or `cfg_mask[in_dest]==0`, item is accepted, not offered, `err_drop` pulses one cycle, state unchanged by that item.
- Undefined: no `in_dest` port, pure round-robin; `err_drop` tied 0.

## Structure
- Package `demux_sched_pkg`: state enum (`IDLE`, `HOLD`), `CNT_W = 16`, index-width helper function.
- Sub-module `rr_pick`: combinational, inputs mask and last pointer, outputs next index and `any` flag; reused in round-robin mode only.

## Test plan
- Reset then N_OUT=4, mask 4'b1111, all ready, 8 items 0x10..0x17 → ports 0,1,2,3,0,1,2,3 one per cycle, `dispatch_cnt`=8.
- Mask 4'b1010, 4 items → ports 1,3,1,3; ports 0 and 2 never valid.
- Port 2 ready low for 5 cycles while targeted → `out_valid`=4'b0100 and data held stable, `in_ready` low; released → fire, next item to port 3.
- Mask cleared to 0 while item held on port 1 → item completes on port 1, then `in_ready` stays 0 until mask nonzero.
- `rst_n` low while in `HOLD` → `out_valid` 0 same cycle; after release first item goes to port 0.
- With `DEMUX_SCHED_DEST_EN`: dest 2 → port 2; dest 2 with mask 4'b1011 → `err_drop` one pulse, no `out_valid`, `dispatch_cnt` unchanged.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the demux_sched 1:N scheduler.
package demux_sched_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Width of an index into n ports; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_sched_rr_pick.sv
// Round-robin picker: first enabled port strictly after the last one, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin : pick
    logic found;
    int unsigned c;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      c = (32'(last_i) + i) % N;
      if (!found && mask_i[IW'(c)]) begin
        idx_o = IW'(c);
        found = 1'b1;
      end
    end
    any_o = |mask_i;
  end

endmodule

// File: rtl/demux_sched.sv
// 1:N demux scheduler with a single holding register; round-robin targets, or
// explicit in_dest targets when built with DEMUX_SCHED_DEST_EN.
module demux_sched
  import demux_sched_pkg::*;
#(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_OUT-1:0]          cfg_mask,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
`ifdef DEMUX_SCHED_DEST_EN
  input  logic [idx_w(N_OUT)-1:0]   in_dest,
`endif
  output logic [N_OUT-1:0]          out_valid,
  input  logic [N_OUT-1:0]          out_ready,
  output logic [DW-1:0]             out_data,
  output logic [CNT_W-1:0]          dispatch_cnt,
  output logic                      err_drop
);

  localparam int unsigned IW = idx_w(N_OUT);

  state_e             state_q, state_d;
  logic [N_OUT-1:0]   valid_q, valid_d;
  logic [DW-1:0]      data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               out_fire_c;
  logic               accept_c;

  assign out_fire_c = |(valid_q & out_ready);
  assign in_ready   = ((state_q == IDLE) || out_fire_c) && (|cfg_mask);
  assign accept_c   = in_valid && in_ready;

`ifdef DEMUX_SCHED_DEST_EN
  logic [N_OUT-1:0]   mask_sh_c;
  logic               dest_ok_c;

  // Out-of-range or masked destinations are swallowed and flagged.
  assign mask_sh_c = cfg_mask >> in_dest;
  assign dest_ok_c = (32'(in_dest) < N_OUT) && mask_sh_c[0];
`else
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      rr_idx_c;
  logic               rr_any_c;

  rr_pick #(
    .N  (N_OUT),
    .IW (IW)
  ) u_rr_pick (
    .mask_i (cfg_mask),
    .last_i (last_q),
    .idx_o  (rr_idx_c),
    .any_o  (rr_any_c)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifndef DEMUX_SCHED_DEST_EN
      last_q  <= IW'(N_OUT - 1);
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifndef DEMUX_SCHED_DEST_EN
      last_q  <= last_d;
`endif
    end
  end

  // Accept takes priority over retire so a firing slot can be refilled in the same cycle.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q + CNT_W'(out_fire_c);
    err_d   = 1'b0;
`ifdef DEMUX_SCHED_DEST_EN
    if (accept_c && dest_ok_c) begin
      data_d  = in_data;
      valid_d = N_OUT'(1) << in_dest;
      state_d = HOLD;
    end else if (out_fire_c) begin
      valid_d = '0;
      state_d = IDLE;
    end
    err_d = accept_c && !dest_ok_c;
`else
    last_d = last_q;
    if (accept_c && rr_any_c) begin
      data_d  = in_data;
      valid_d = N_OUT'(1) << rr_idx_c;
      last_d  = rr_idx_c;
      state_d = HOLD;
    end else if (out_fire_c) begin
      valid_d = '0;
      state_d = IDLE;
    end
`endif
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign dispatch_cnt = cnt_q;
  assign err_drop     = err_q;

endmodule

// File: tb/tb_demux_sched.sv
// Randomised self-checking bench for demux_sched against a transaction-level model.
module tb_demux_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  cfg_mask;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_dest;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW-1:0] out_data;
  logic [15:0]   dispatch_cnt;
  logic          err_drop;

  always #5 clk = ~clk;

  demux_sched #(.N_OUT(N), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_mask     (cfg_mask),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
`ifdef DEMUX_SCHED_DEST_EN
    .in_dest      (in_dest),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .dispatch_cnt (dispatch_cnt),
    .err_drop     (err_drop)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: at most one item held, remembered as (port, payload).
  bit            m_held;
  int            m_port;
  logic [DW-1:0] m_data;
  int            m_last;
  int            m_cnt;
  bit            m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] m, input int last);
    int p;
    for (int k = 1; k <= N; k++) begin
      p = (last + k) % N;
      if (m[p[1:0]]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_held = 0; m_port = 0; m_data = '0; m_last = N - 1; m_cnt = 0; m_err = 0;
  endtask

  // Drive one cycle of inputs, check outputs, then advance the model across the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [N-1:0] mask,
                       input logic [N-1:0] rdy, input logic [IW-1:0] dest);
    logic [N-1:0] exp_valid;
    bit fire, rdy_exp, acc, good;
    int t;
    @(negedge clk);
    in_valid = v; in_data = d; cfg_mask = mask; out_ready = rdy; in_dest = dest;
    #1;
    exp_valid = m_held ? (N'(1) << m_port) : '0;
    fire    = m_held && rdy[m_port[1:0]];
    rdy_exp = (!m_held || fire) && (mask != 0);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("in_ready", 32'(in_ready), 32'(rdy_exp));
    chk("dispatch_cnt", 32'(dispatch_cnt), 32'(m_cnt % 65536));
    chk("err_drop", 32'(err_drop), 32'(m_err));
    acc = v && rdy_exp;
`ifdef DEMUX_SCHED_DEST_EN
    t    = int'(dest);
    good = (t < N) && mask[dest];
`else
    t    = rr_next(mask, m_last);
    good = 1;
`endif
    m_err = acc && !good;
    if (acc && good) begin
      m_held = 1; m_port = t; m_data = d;
`ifndef DEMUX_SCHED_DEST_EN
      m_last = t;
`endif
    end else if (fire) begin
      m_held = 0;
    end
    if (fire) m_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_cnt", 32'(dispatch_cnt), 32'h0);
    chk("rst_err", 32'(err_drop), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic v;
    logic [N-1:0] mask, rdy;
    rst_n = 0; in_valid = 0; in_data = '0; cfg_mask = '0; out_ready = '0; in_dest = '0;
    model_reset();
    #12;
    do_reset();

`ifndef DEMUX_SCHED_DEST_EN
    // Full mask, consumers always ready: back-to-back rotation over all ports.
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(8'h10 + i), 4'b1111, 4'b1111, '0);
    cycle(1'b0, '0, 4'b1111, 4'b1111, '0);
    cycle(1'b0, '0, 4'b1111, 4'b1111, '0);
    chk("cnt_after8", 32'(dispatch_cnt), 32'd8);

    // Sparse mask alternates between ports 1 and 3.
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h20 + i), 4'b1010, 4'b1111, '0);
    cycle(1'b0, '0, 4'b1010, 4'b1111, '0);

    // Stall port 2, then release; next item lands on port 3.
    do_reset();
    cycle(1'b1, 8'h30, 4'b1111, 4'b1111, '0);
    cycle(1'b1, 8'h31, 4'b1111, 4'b1111, '0);
    cycle(1'b1, 8'h32, 4'b1111, 4'b1011, '0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h33, 4'b1111, 4'b1011, '0);
    chk("stall_valid", 32'(out_valid), 32'h4);
    chk("stall_data", 32'(out_data), 32'h32);
    cycle(1'b1, 8'h33, 4'b1111, 4'b1111, '0);
    cycle(1'b0, '0, 4'b1111, 4'b0000, '0);
    chk("after_stall_port3", 32'(out_valid), 32'h8);

    // Mask cleared while an item sits on port 1.
    do_reset();
    cycle(1'b1, 8'h40, 4'b1111, 4'b0000, '0);
    cycle(1'b1, 8'h41, 4'b1111, 4'b0001, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h42, 4'b0000, 4'b0000, '0);
    cycle(1'b1, 8'h42, 4'b0000, 4'b0010, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h43, 4'b0000, 4'b1111, '0);
    chk("mask0_idle_valid", 32'(out_valid), 32'h0);
    chk("mask0_in_ready", 32'(in_ready), 32'h0);

    // Reset while holding, first post-reset item goes to port 0.
    cycle(1'b1, 8'h50, 4'b1111, 4'b0000, '0);
    cycle(1'b0, '0, 4'b1111, 4'b0000, '0);
    do_reset();
    cycle(1'b1, 8'h51, 4'b1111, 4'b0000, '0);
    cycle(1'b0, '0, 4'b1111, 4'b0000, '0);
    chk("post_reset_port0", 32'(out_valid), 32'h1);
`else
    // Explicit destination, then a destination that is masked off.
    cycle(1'b1, 8'h60, 4'b1111, 4'b0000, 2'd2);
    cycle(1'b0, '0, 4'b1111, 4'b0000, 2'd0);
    chk("dest2_valid", 32'(out_valid), 32'h4);
    cycle(1'b0, '0, 4'b1111, 4'b1111, 2'd0);
    cycle(1'b1, 8'h61, 4'b1011, 4'b1111, 2'd2);
    cycle(1'b0, '0, 4'b1011, 4'b1111, 2'd0);
    chk("drop_pulse", 32'(err_drop), 32'h1);
    chk("drop_no_valid", 32'(out_valid), 32'h0);
    chk("drop_cnt", 32'(dispatch_cnt), 32'h1);
    cycle(1'b0, '0, 4'b1011, 4'b1111, 2'd0);
`endif

    // Randomised traffic with occasional mask changes, stalls and resets.
    mask = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mask = N'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      rdy = N'($urandom) | (($urandom_range(0, 1) == 1) ? 4'b1111 : 4'b0000);
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(v, DW'($urandom), mask, rdy, IW'($urandom));
    end
    cycle(1'b0, '0, mask, 4'b1111, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
